// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles every cache-side and memory-side signal of the memory arbiter.
//   The arbiter connects through the 'slave' modport. The instruction cache,
//   the data cache and the burst memory together form the 'master' side.
//
//   icache : i_read, i_addr -> ; <- i_rdata, i_resp
//   dcache : d_read, d_write, d_addr, d_wdata -> ; <- d_rdata, d_resp
//   memory : <- pmem_read, pmem_write, pmem_addr, pmem_wdata ;
//            pmem_rdata, pmem_resp ->
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
    // icache side
    logic         i_read;
    logic [31:0]  i_addr;
    logic [255:0] i_rdata;
    logic         i_resp;
    // dcache side
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    // burst memory side
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_addr;
    logic [63:0]  pmem_wdata;
    logic [63:0]  pmem_rdata;
    logic         pmem_resp;

    modport slave (
        input  i_read, i_addr,
        output i_rdata, i_resp,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_addr, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output i_read, i_addr,
        input  i_rdata, i_resp,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_addr, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one 64-bit burst memory port between an instruction cache and a
//   data cache. Every transfer is a 256-bit line moved as four 64-bit beats.
//   When both caches request in the same cycle, DCACHE_PRIORITY picks the
//   winner. The losing cache keeps its request high and is served next.
//
//   Parameters
//     DCACHE_PRIORITY : 1 = the dcache wins a tie, 0 = the icache wins a tie
//   Ports
//     clk : clock; all state changes on its rising edge
//     rst : asynchronous reset, active low
//     bus : mem_arbiter_if.slave, which carries the cache and memory signals
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int DCACHE_PRIORITY = 1
) (
    input  logic        clk,
    input  logic        rst,
    mem_arbiter_if.slave bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] I_RD   = 3'd1;
    localparam logic [2:0] D_RD   = 3'd2;
    localparam logic [2:0] D_WR   = 3'd3;
    localparam logic [2:0] DONE_I = 3'd4;
    localparam logic [2:0] DONE_D = 3'd5;

    logic [2:0]   state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [31:0]  addr_q, addr_d;
    logic [255:0] wdata_q, wdata_d;
    logic [255:0] line_q, line_d;

    logic d_req;
    logic pick_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        line_d  = line_q;

        d_req  = bus.d_read | bus.d_write;
        // The dcache wins a tie only when it has priority.
        // With no icache request it wins regardless.
        pick_d = d_req && ((DCACHE_PRIORITY != 0) || !bus.i_read);

        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    // A writeback takes precedence when d_read and d_write are both high.
                    state_d = bus.d_write ? D_WR : D_RD;
                    addr_d  = bus.d_addr & ~32'h1F;
                    wdata_d = bus.d_wdata;
                    cnt_d   = 2'd0;
                end else if (bus.i_read) begin
                    state_d = I_RD;
                    addr_d  = bus.i_addr & ~32'h1F;
                    cnt_d   = 2'd0;
                end
            end
            I_RD, D_RD, D_WR: begin
                // Without pmem_resp the current beat is held.
                if (bus.pmem_resp) begin
                    cnt_d = cnt_q + 2'd1;
                    if (state_q != D_WR) begin
                        line_d[{cnt_q, 6'd0} +: 64] = bus.pmem_rdata;
                    end
                    if (cnt_q == 2'd3) begin
                        state_d = (state_q == I_RD) ? DONE_I : DONE_D;
                    end
                end
            end
            DONE_I, DONE_D: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 256'd0;
            line_q  <= 256'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            line_q  <= line_d;
        end
    end

    // The memory outputs are decoded from registers only. An asserted reset
    // therefore clears them at once, without waiting for a clock edge.
    assign bus.pmem_read  = (state_q == I_RD) || (state_q == D_RD);
    assign bus.pmem_write = (state_q == D_WR);
    assign bus.pmem_addr  = addr_q;
    assign bus.pmem_wdata = wdata_q[{cnt_q, 6'd0} +: 64];

    assign bus.i_resp  = (state_q == DONE_I);
    assign bus.d_resp  = (state_q == DONE_D);
    // Both caches read the same line buffer.
    // The buffer is only overwritten when the next read burst starts.
    assign bus.i_rdata = line_q;
    assign bus.d_rdata = line_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DCACHE_PRIORITY, default 1; 1 = dcache wins simultaneous requests, 0 = icache wins.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports i_read input 1 icache line-fill request; i_addr input 32 icache byte address.
REQ-005 SHALL have ports i_rdata output 256 icache fill line; i_resp output 1 icache transfer complete.
REQ-006 SHALL have ports d_read input 1 and d_write input 1 dcache fill / writeback requests; d_addr input 32 dcache byte address.
REQ-007 SHALL have ports d_wdata input 256 writeback line; d_rdata output 256 dcache fill line; d_resp output 1 dcache transfer complete.
REQ-008 SHALL have ports pmem_read output 1, pmem_write output 1, pmem_addr output 32, pmem_wdata output 64 to burst memory.
REQ-009 SHALL have ports pmem_rdata input 64 read beat; pmem_resp input 1 marks one beat accepted/valid that cycle.

Function
REQ-010 SHALL implement FSM states IDLE, I_RD, D_RD, D_WR, DONE_I, DONE_D.
REQ-011 IDLE: pending request sampled at edge -> next state I_RD, D_RD or D_WR; no request -> stay IDLE.
REQ-012 Both caches requesting in IDLE -> DCACHE_PRIORITY selects winner; loser remains pending and is served next.
REQ-013 d_read and d_write both high -> D_WR chosen (write precedence).
REQ-014 pmem_read SHALL be high exactly in I_RD/D_RD; pmem_write exactly in D_WR; never both.
REQ-015 pmem_addr SHALL be {selected addr[31:5], 5'b0}, address latched on entry, stable for whole burst.
REQ-016 Each burst SHALL be 4 beats counted by a 2-bit counter cleared on entry; counter increments only on pmem_resp.
REQ-017 Beat k (k=0..3) SHALL map to line bits [64k+63:64k]; read beat k captured into a 256-bit line buffer; pmem_wdata = latched d_wdata beat k.
REQ-018 Beats MAY be separated by idle cycles (pmem_resp low); state and counter SHALL hold.
REQ-019 pmem_resp on beat 3 -> DONE_I (from I_RD) or DONE_D (from D_RD/D_WR) next cycle.
REQ-020 DONE_I SHALL assert i_resp for exactly one cycle; DONE_D asserts d_resp for exactly one cycle; then IDLE.
REQ-021 i_rdata/d_rdata SHALL drive line buffer contents, valid during respective resp cycle, held until next read burst starts.
REQ-022 Latency: request sampled edge N -> pmem_* active in cycle N+1; minimum request-to-resp 6 cycles with back-to-back beats.
REQ-023 Requesters hold request until resp; requester drops it the cycle after resp; IDLE after DONE SHALL not re-issue the served request.
REQ-024 pmem_resp in IDLE/DONE states SHALL be ignored.
REQ-025 Requests changing during a burst SHALL not affect the active burst.

Reset
REQ-026 rst low SHALL immediately (asynchronously) force IDLE, counter 0, line buffer 0.
REQ-027 During reset: pmem_read=0, pmem_write=0, pmem_addr=0, pmem_wdata=0, i_resp=0, d_resp=0, i_rdata=0, d_rdata=0.
REQ-028 Reset mid-burst SHALL abort the burst; no resp issued; first post-reset cycle is IDLE.

Verification
REQ-029 i_read, i_addr=0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. back-to-back -> pmem_addr=0x0000_1220, i_resp one cycle, i_rdata={0x44..,0x33..,0x22..,0x11..}.
REQ-030 d_write, d_addr=0x8000_0040, d_wdata beats A,B,C,D, pmem_resp with 2 idle cycles between beats -> pmem_wdata A,B,C,D in order, pmem_write held 4 beats + gaps, one d_resp.
REQ-031 i_read and d_read same cycle, DCACHE_PRIORITY=1 -> dcache burst first, d_resp, then icache burst, i_resp; repeat with 0 -> reversed order.
REQ-032 d_read and d_write both high -> pmem_write only, pmem_read never high.
REQ-033 rst low after beat 2 of an icache read -> pmem_read drops same cycle, no i_resp; after release, new d_read completes normally.
REQ-034 Random pmem_resp gaps, 1000 mixed requests vs. reference model -> every request gets exactly one resp with matching data; pmem_read/pmem_write never both high.
